// File: rtl/avalon_slave_regfile.sv
// ---------------------------------------------------------------------------
// avalon_slave_regfile
//
// Avalon-MM slave register file for a fixed-timing master (no waitrequest).
// Each write-strobe assertion commits exactly once. Read data comes back a
// fixed READ_LATENCY cycles after the first read-strobe cycle. Access and
// protocol-error statistics are kept for scoreboarding.
//
// Register map (full address compare):
//   0 .. NUM_REGS-1 : general read/write registers
//   0x10 ID         : read-only, ID_VALUE
//   0x11 RDCNT      : read-only, read access count
//   0x12 WRCNT      : read-only, write access count
//   0x13 ERRCNT     : read-only, protocol/decode error count
//   0x14 CTRL       : write bit0=1 clears counters and errorFlag; reads 0
//
// Ports:
//   clk                 clock
//   reset               asynchronous, active-high reset
//   avslave_chipselect  slave select
//   avslave_read        read strobe
//   avslave_write       write strobe
//   avslave_address     word address (ADDRESS_SIZE bits)
//   avslave_writedata   write data (DATA_SIZE bits)
//   avslave_readdata    read data (DATA_SIZE bits)
//   busy                high while the access FSM is not idle
//   errorFlag           sticky protocol/decode error flag
// ---------------------------------------------------------------------------
module avalon_slave_regfile #(
   parameter int          ADDRESS_SIZE = 32,
   parameter int          DATA_SIZE    = 32,
   parameter int          NUM_REGS     = 8,
   parameter int          READ_LATENCY = 0,
   parameter int          COUNT_SIZE   = 16,
   parameter logic [31:0] ID_VALUE     = 32'hA5A50001
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    avslave_chipselect,
   input  logic                    avslave_read,
   input  logic                    avslave_write,
   input  logic [ADDRESS_SIZE-1:0] avslave_address,
   input  logic [DATA_SIZE-1:0]    avslave_writedata,
   output logic [DATA_SIZE-1:0]    avslave_readdata,
   output logic                    busy,
   output logic                    errorFlag
);

   localparam int IDX_W = $clog2(NUM_REGS);

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_ERROR} state_t;

   state_t                state, next_state;
   logic [DATA_SIZE-1:0]  regs [NUM_REGS];
   logic [COUNT_SIZE-1:0] rdcnt, wrcnt, errcnt;

   logic [63:0]           addr_ext;
   logic [IDX_W-1:0]      reg_idx;
   logic                  hit_gen, hit_id, hit_rdcnt, hit_wrcnt, hit_errcnt, hit_ctrl;
   logic                  rd_legal, wr_legal;
   logic                  acc_wr, acc_rd, acc_both;
   logic                  start_wr, start_rd, start_err;
   logic                  clear_stats, decode_err;
   logic [DATA_SIZE-1:0]  rd_p0;

   // Statistic counters wrap from all-ones back to zero.
   function automatic logic [COUNT_SIZE-1:0] inc_wrap(input logic [COUNT_SIZE-1:0] v);
      return v + COUNT_SIZE'(1);
   endfunction

   function automatic logic [DATA_SIZE-1:0] zext_count(input logic [COUNT_SIZE-1:0] v);
      return DATA_SIZE'(v);
   endfunction

   // Address decode: widen to 64 bits so every comparison is a full compare
   // regardless of ADDRESS_SIZE.
   always_comb begin
      addr_ext   = 64'(avslave_address);
      reg_idx    = addr_ext[IDX_W-1:0];
      hit_gen    = (addr_ext < 64'(NUM_REGS));
      hit_id     = (addr_ext == 64'h10);
      hit_rdcnt  = (addr_ext == 64'h11);
      hit_wrcnt  = (addr_ext == 64'h12);
      hit_errcnt = (addr_ext == 64'h13);
      hit_ctrl   = (addr_ext == 64'h14);
      rd_legal   = hit_gen | hit_id | hit_rdcnt | hit_wrcnt | hit_errcnt | hit_ctrl;
      wr_legal   = hit_gen | hit_ctrl;
   end

   assign acc_wr   = avslave_chipselect &  avslave_write & ~avslave_read;
   assign acc_rd   = avslave_chipselect &  avslave_read  & ~avslave_write;
   assign acc_both = avslave_chipselect &  avslave_read  &  avslave_write;

   // Access FSM: only the IDLE state starts an access, so a strobe held for
   // several cycles is counted and committed once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      start_wr   = 1'b0;
      start_rd   = 1'b0;
      start_err  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (acc_wr) begin
               start_wr   = 1'b1;
               next_state = ST_WRITE;
            end else if (acc_rd) begin
               start_rd   = 1'b1;
               next_state = ST_READ;
            end else if (acc_both) begin
               start_err  = 1'b1;
               next_state = ST_ERROR;
            end
         end
         ST_WRITE: if (!(avslave_chipselect && avslave_write)) next_state = ST_IDLE;
         ST_READ:  if (!(avslave_chipselect && avslave_read))  next_state = ST_IDLE;
         ST_ERROR: if (!(avslave_chipselect && (avslave_read || avslave_write)))
                      next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

   assign clear_stats = start_wr & hit_ctrl & avslave_writedata[0];
   assign decode_err  = start_err | (start_wr & ~wr_legal) | (start_rd & ~rd_legal);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (start_wr && hit_gen) begin
         regs[reg_idx] <= avslave_writedata;
      end
   end

   // A CTRL clear overrides every same-cycle increment, including the WRCNT
   // increment of the clearing write itself.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdcnt     <= '0;
         wrcnt     <= '0;
         errcnt    <= '0;
         errorFlag <= 1'b0;
      end else if (clear_stats) begin
         rdcnt     <= '0;
         wrcnt     <= '0;
         errcnt    <= '0;
         errorFlag <= 1'b0;
      end else begin
         if (start_rd) rdcnt <= inc_wrap(rdcnt);
         if (start_wr) wrcnt <= inc_wrap(wrcnt);
         if (decode_err) begin
            errcnt    <= inc_wrap(errcnt);
            errorFlag <= 1'b1;
         end
      end
   end

   // Stage 0: read mux, evaluated every cycle independent of the FSM so data
   // stays valid for as long as the strobe is held.
   always_comb begin
      rd_p0 = '0;
      if (acc_rd) begin
         if (hit_gen)         rd_p0 = regs[reg_idx];
         else if (hit_id)     rd_p0 = DATA_SIZE'(ID_VALUE);
         else if (hit_rdcnt)  rd_p0 = zext_count(rdcnt);
         else if (hit_wrcnt)  rd_p0 = zext_count(wrcnt);
         else if (hit_errcnt) rd_p0 = zext_count(errcnt);
      end
   end

   // Stages 1..READ_LATENCY: plain delay line.
   generate
      if (READ_LATENCY == 0) begin : g_comb
         assign avslave_readdata = rd_p0;
      end else begin : g_pipe
         logic [DATA_SIZE-1:0] rd_pn [READ_LATENCY];
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < READ_LATENCY; i++) rd_pn[i] <= '0;
            end else begin
               rd_pn[0] <= rd_p0;
               for (int i = 1; i < READ_LATENCY; i++) rd_pn[i] <= rd_pn[i-1];
            end
         end
         assign avslave_readdata = rd_pn[READ_LATENCY-1];
      end
   endgenerate

endmodule
